adder_result_checker: RTL and testbench
=======================================

# adder_result_checker

Synthesizable, self-checking receiver for adder result streams. It accepts one operand/result vector per handshake: operands `in1`, `in2`, `cin` plus the DUT outputs `sum`, `cout`, `OF` taken from a `carry_select_adder` or `CSA` instance. It computes the golden N-bit signed sum internally, compares, and keeps pass/fail counters and a first-failure capture. It sits on the result side of adder bring-up logic and replaces waveform inspection with hardware-counted verdicts.

## Interface
- `N`, 32, operand/sum width in bits (≥2)
- `CW`, 16, width of test-count, index and pass/fail counters
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse: clear counters and captures, arm a run
- `num_tests`  in  CW  vectors to accept in this run; sampled on `start`
- `in_valid`  in  1  vector present on the inputs below
- `in_ready`  out  1  checker accepts a vector this cycle
- `in1`, `in2`  in  N each  signed operands
- `cin`  in  1  carry-in
- `dut_sum`  in  N  DUT sum
- `dut_cout`  in  1  DUT carry-out
- `dut_of`  in  1  DUT overflow
- `busy`  out  1  high in RUN or DRAIN
- `done`  out  1  run complete; held until next `start`
- `pass_cnt`, `fail_cnt`  out  CW each  saturating verdict counters
- `first_fail_valid`  out  1  at least one mismatch seen this run
- `first_fail_idx`  out  CW  0-based index of the first mismatching vector
- `first_fail_sum`  out  N  `dut_sum` of that vector

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE. Reset enters IDLE. In reset, every output is 0.
- `start` in any state:
  - clears both counters, the accept index and all `first_fail_*` outputs
  - latches `num_tests`
  - goes to RUN, or to DONE if `num_tests`=0
- `start` has priority over a same-cycle handshake; that vector is dropped.
- In RUN, `in_ready` is 1 while the accept index is below `num_tests`. `in_ready` is 0 in every other state.
- A handshake (`in_valid`&`in_ready`) registers the vector into stage 1 and increments the accept index.
- When the accept index reaches `num_tests`, the FSM moves RUN→DRAIN and `in_ready` drops in the same cycle.
- Stage 1 computes the golden result:
  - {g_cout, g_sum} = zero-extended `in1` + `in2` + `cin`, an (N+1)-bit unsigned sum
  - g_of = (in1[N-1]==in2[N-1]) & (g_sum[N-1]!=in1[N-1])
- Stage 2 compares the DUT result against the golden result:
  - Mismatch means `dut_sum`≠g_sum, or a flag mismatch as defined under Configuration.
  - A mismatch increments `fail_cnt`; otherwise `pass_cnt` increments.
  - Both counters saturate at 2^CW−1.
- On the first mismatch of a run, stage 2 sets `first_fail_valid` and loads the index and `dut_sum`. Later mismatches do not overwrite the capture.
- DRAIN→DONE happens once stage 1 is empty. DONE is held until `start` arrives.
- Holding `in_valid` low stalls the run indefinitely; no timeout.
- Asserting `rst` mid-run discards in-flight vectors and returns to IDLE immediately.

## Timing
- Handshake at edge k: stage 1 loads at k, and counters and `first_fail_*` update at edge k+1.
- `done` rises at edge k+2 after the final handshake at edge k. `busy` falls on the same edge.
- `start` at edge t: RUN and `in_ready`=1 from t+1 onward. With `num_tests`=0, `done`=1 from t+1.
- Full throughput is one vector per cycle. Back-to-back handshakes need no bubbles.
- Inputs are sampled only on the handshake edge and need not be held afterwards.
- The DUT is combinational. The bench presents operands and DUT outputs in the same cycle.

## Configuration
- `CHECK_FLAGS_EN` defined:
  - a mismatch also includes `dut_cout`≠g_cout or `dut_of`≠g_of
  - vectors where only the flags differ count as failures
- `CHECK_FLAGS_EN` undefined:
  - only `sum` is compared; `dut_cout`/`dut_of` are ignored
  - the golden flag logic is not synthesized

## Test plan
- Reset then idle: `rst` pulse, no `start` → every output 0, `in_ready`=0 indefinitely.
- Positive overflow, correct DUT: `start`, `num_tests`=1; in1=in2=0x40000000, cin=0, dut_sum=0x80000000, dut_cout=0, dut_of=1 → `pass_cnt`=1, `fail_cnt`=0, `done` two edges after the handshake.
- Flag-only error: in1=in2=0x80000001, cin=0, dut_sum=0x00000002, dut_cout=1, dut_of=0.
  - With `CHECK_FLAGS_EN`: `fail_cnt`=1, `first_fail_idx`=0, `first_fail_sum`=0x00000002.
  - Without it: `pass_cnt`=1.
- Mixed stream: `num_tests`=4, back-to-back.
  - vector 0: 1+1 cin0 sum 2 (pass)
  - vector 1: 2+2 cin1 sum 4, should be 5 (fail)
  - vector 2: 0x16+0x16 cin1 sum 0x2D (pass)
  - vector 3: 0xDE+0xDE cin1 sum 0 (fail)
  - → `pass_cnt`=2, `fail_cnt`=2, `first_fail_idx`=1, `first_fail_sum`=4.
- Stall and restart: `num_tests`=3, `in_valid` gaps of 5 cycles → `in_ready` stays high and counts are correct. Then `start` in DONE → all counts cleared and a new run proceeds.
- Mid-run reset: assert `rst` one cycle after the 2nd of 3 handshakes → all outputs 0 and IDLE; a following `start` run counts from 0.

Source files
------------

// File: rtl/adder_result_checker.sv
// Self-checking receiver for adder result streams: golden N-bit sum, pass/fail counters, first-failure capture.
// Optional CHECK_FLAGS_EN also compares carry-out and signed overflow.
module adder_result_checker #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_tests,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in1,
  input  logic [N-1:0]  in2,
  input  logic          cin,
  input  logic [N-1:0]  dut_sum,
  input  logic          dut_cout,
  input  logic          dut_of,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic          first_fail_valid,
  output logic [CW-1:0] first_fail_idx,
  output logic [N-1:0]  first_fail_sum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] idx_inc;

  logic          s1_vld_q, s1_vld_d;
  logic [N-1:0]  s1_gsum_q, s1_gsum_d;
  logic [N-1:0]  s1_dsum_q, s1_dsum_d;
  logic [CW-1:0] s1_idx_q, s1_idx_d;

  logic [CW-1:0] pass_q, pass_d;
  logic [CW-1:0] fail_q, fail_d;
  logic          ffv_q, ffv_d;
  logic [CW-1:0] ffi_q, ffi_d;
  logic [N-1:0]  ffs_q, ffs_d;

  logic [N-1:0]  g_sum;
  logic          hs;
  logic          mismatch;
  logic          flag_err;

`ifdef CHECK_FLAGS_EN
  logic [N:0] g_full;
  logic       g_cout, g_of;
  logic       s1_gcout_q, s1_gcout_d;
  logic       s1_gof_q, s1_gof_d;
  logic       s1_dcout_q, s1_dcout_d;
  logic       s1_dof_q, s1_dof_d;

  assign g_full = {1'b0, in1} + {1'b0, in2} + {{N{1'b0}}, cin};
  assign g_sum  = g_full[N-1:0];
  assign g_cout = g_full[N];
  assign g_of   = (in1[N-1] == in2[N-1]) & (g_sum[N-1] != in1[N-1]);

  assign flag_err = (s1_dcout_q != s1_gcout_q) | (s1_dof_q != s1_gof_q);

  always_comb begin
    s1_gcout_d = s1_gcout_q;
    s1_gof_d   = s1_gof_q;
    s1_dcout_d = s1_dcout_q;
    s1_dof_d   = s1_dof_q;
    if (hs) begin
      s1_gcout_d = g_cout;
      s1_gof_d   = g_of;
      s1_dcout_d = dut_cout;
      s1_dof_d   = dut_of;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_gcout_q <= 1'b0;
      s1_gof_q   <= 1'b0;
      s1_dcout_q <= 1'b0;
      s1_dof_q   <= 1'b0;
    end else begin
      s1_gcout_q <= s1_gcout_d;
      s1_gof_q   <= s1_gof_d;
      s1_dcout_q <= s1_dcout_d;
      s1_dof_q   <= s1_dof_d;
    end
  end
`else
  logic unused_flags;

  assign g_sum        = in1 + in2 + {{(N-1){1'b0}}, cin};
  assign flag_err     = 1'b0;
  assign unused_flags = dut_cout ^ dut_of;
`endif

  assign in_ready = (state_q == RUN) && (idx_q < num_q);
  // start wins over a same-cycle handshake, so the offered vector is dropped
  assign hs       = in_valid & in_ready & ~start;
  assign idx_inc  = idx_q + {{(CW-1){1'b0}}, 1'b1};
  assign mismatch = (s1_dsum_q != s1_gsum_q) | flag_err;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    idx_d     = idx_q;
    s1_vld_d  = 1'b0;
    s1_gsum_d = s1_gsum_q;
    s1_dsum_d = s1_dsum_q;
    s1_idx_d  = s1_idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ffv_d     = ffv_q;
    ffi_d     = ffi_q;
    ffs_d     = ffs_q;

    if (start) begin
      state_d = (num_tests == '0) ? DONE : RUN;
      num_d   = num_tests;
      idx_d   = '0;
      pass_d  = '0;
      fail_d  = '0;
      ffv_d   = 1'b0;
      ffi_d   = '0;
      ffs_d   = '0;
    end else begin
      if (hs) begin
        s1_vld_d  = 1'b1;
        s1_gsum_d = g_sum;
        s1_dsum_d = dut_sum;
        s1_idx_d  = idx_q;
        idx_d     = idx_inc;
      end

      if (s1_vld_q) begin
        if (mismatch) begin
          if (fail_q != '1) fail_d = fail_q + {{(CW-1){1'b0}}, 1'b1};
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = s1_idx_q;
            ffs_d = s1_dsum_q;
          end
        end else if (pass_q != '1) begin
          pass_d = pass_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      case (state_q)
        RUN:     if (hs && (idx_inc == num_q)) state_d = DRAIN;
        DRAIN:   if (!s1_vld_q) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      idx_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_gsum_q <= '0;
      s1_dsum_q <= '0;
      s1_idx_q  <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      ffv_q     <= 1'b0;
      ffi_q     <= '0;
      ffs_q     <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      s1_vld_q  <= s1_vld_d;
      s1_gsum_q <= s1_gsum_d;
      s1_dsum_q <= s1_dsum_d;
      s1_idx_q  <= s1_idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ffv_q     <= ffv_d;
      ffi_q     <= ffi_d;
      ffs_q     <= ffs_d;
    end
  end

  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);
  assign pass_cnt         = pass_q;
  assign fail_cnt         = fail_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_sum   = ffs_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Randomised and directed bench for adder_result_checker against a behavioural arithmetic model.
module tb_adder_result_checker;
  localparam int N  = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_tests;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in1, in2;
  logic          cin;
  logic [N-1:0]  dut_sum;
  logic          dut_cout, dut_of;
  logic          busy, done;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic          first_fail_valid;
  logic [CW-1:0] first_fail_idx;
  logic [N-1:0]  first_fail_sum;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [31:0] a, b;
    logic        c;
    logic [31:0] s;
    logic        co, of;
  } vec_t;

  vec_t vq[$];

  adder_result_checker #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2), .cin(cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout), .dut_of(dut_of),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .first_fail_sum(first_fail_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden result from integer arithmetic: unsigned 33-bit sum and true signed range test
  function automatic void golden(input logic [31:0] a, input logic [31:0] b, input logic c,
                                 output logic [31:0] gs, output logic gc, output logic go);
    longint unsigned u;
    longint          s;
    u  = 64'(a) + 64'(b) + 64'(c);
    s  = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    gs = u[31:0];
    gc = u[32];
    go = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic bit ref_fail(input vec_t v);
    logic [31:0] gs;
    logic        gc, go;
    golden(v.a, v.b, v.c, gs, gc, go);
`ifdef CHECK_FLAGS_EN
    return (gs != v.s) || (gc != v.co) || (go != v.of);
`else
    return gs != v.s;
`endif
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic c,
                              input logic [31:0] s);
    vec_t        v;
    logic [31:0] gs;
    v.a = a; v.b = b; v.c = c;
    golden(a, b, c, gs, v.co, v.of);
    v.s = s;
    return v;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(3, 0))
      0:       return 32'h7FFF_FFFF ^ 32'($urandom_range(3, 0));
      1:       return 32'h8000_0000 | 32'($urandom_range(3, 0));
      default: return $urandom();
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t        v;
    logic [31:0] gs;
    int unsigned r;
    v.a = pick(); v.b = pick(); v.c = 1'($urandom_range(1, 0));
    golden(v.a, v.b, v.c, gs, v.co, v.of);
    v.s = gs;
    r = $urandom_range(5, 0);
    if (r == 0) v.s = v.s ^ (32'h1 << $urandom_range(31, 0));
    if (r == 1) v.co = ~v.co;
    if (r == 2) v.of = ~v.of;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in1 = v.a; in2 = v.b; cin = v.c;
    dut_sum = v.s; dut_cout = v.co; dut_of = v.of;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " pass"}, pass_cnt, 0);
    check({tag, " fail"}, fail_cnt, 0);
    check({tag, " ffv"}, first_fail_valid, 0);
    check({tag, " ffi"}, first_fail_idx, 0);
    check({tag, " ffs"}, first_fail_sum, 0);
  endtask

  // One full run of vq; a deliberately bad vector is offered alongside start and must be dropped
  task automatic run_vectors(input string name, input int unsigned gap_lo, input int unsigned gap_hi);
    int unsigned n, ep, ef, eidx, gap;
    logic        effv;
    logic [31:0] esum;
    n = vq.size(); ep = 0; ef = 0; effv = 0; eidx = 0; esum = 0;
    foreach (vq[i]) begin
      if (ref_fail(vq[i])) begin
        ef++;
        if (!effv) begin effv = 1; eidx = i; esum = vq[i].s; end
      end else ep++;
    end

    start = 1'b1; num_tests = CW'(n);
    drive(mk(32'd1, 32'd1, 1'b0, 32'd7));
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check({name, " start pass"}, pass_cnt, 0);
    check({name, " start fail"}, fail_cnt, 0);
    check({name, " start ffv"}, first_fail_valid, 0);
    if (n == 0) begin
      check({name, " zero done"}, done, 1);
      check({name, " zero busy"}, busy, 0);
      check({name, " zero in_ready"}, in_ready, 0);
      return;
    end
    check({name, " start busy"}, busy, 1);
    check({name, " start done"}, done, 0);

    for (int i = 0; i < int'(n); i++) begin
      drive(vq[i]);
      check({name, " in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i != int'(n) - 1) begin
        gap = $urandom_range(gap_hi, gap_lo);
        repeat (gap) @(posedge clk);
        if (gap != 0) #1;
      end
    end

    check({name, " last in_ready"}, in_ready, 0);
    check({name, " k busy"}, busy, 1);
    check({name, " k done"}, done, 0);
    @(posedge clk); #1;
    check({name, " k1 done"}, done, 0);
    check({name, " k1 pass"}, pass_cnt, ep);
    check({name, " k1 fail"}, fail_cnt, ef);
    @(posedge clk); #1;
    check({name, " k2 done"}, done, 1);
    check({name, " k2 busy"}, busy, 0);
    check({name, " pass"}, pass_cnt, ep);
    check({name, " fail"}, fail_cnt, ef);
    check({name, " ffv"}, first_fail_valid, effv);
    check({name, " ffi"}, first_fail_idx, eidx);
    check({name, " ffs"}, first_fail_sum, esum);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_tests = '0; in_valid = 1'b0;
    in1 = '0; in2 = '0; cin = 1'b0; dut_sum = '0; dut_cout = 1'b0; dut_of = 1'b0;
    #12;
    check_idle("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check_idle("idle");
    end

    vq = {};
    vq.push_back(mk(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000));
    run_vectors("pos_ovf", 0, 0);

    vq = {};
    vq.push_back(mk(32'h8000_0001, 32'h8000_0001, 1'b0, 32'h0000_0002));
    vq[0].co = 1'b1; vq[0].of = 1'b0;
    run_vectors("flag_only", 0, 0);

    vq = {};
    vq.push_back(mk(32'd1, 32'd1, 1'b0, 32'd2));
    vq.push_back(mk(32'd2, 32'd2, 1'b1, 32'd4));
    vq.push_back(mk(32'h16, 32'h16, 1'b1, 32'h2D));
    vq.push_back(mk(32'hDE, 32'hDE, 1'b1, 32'd0));
    run_vectors("mixed", 0, 0);

    vq = {};
    repeat (3) vq.push_back(rand_vec());
    run_vectors("stall", 5, 5);
    vq = {};
    repeat (4) vq.push_back(rand_vec());
    run_vectors("restart", 0, 1);

    vq = {};
    run_vectors("zero", 0, 0);

    // Mid-run reset one cycle after the second of three handshakes
    start = 1'b1; num_tests = CW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    drive(mk(32'd5, 32'd6, 1'b0, 32'd0));
    @(posedge clk); #1;
    drive(mk(32'd7, 32'd8, 1'b0, 32'd15));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_idle("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("post_rst");
    vq = {};
    repeat (5) vq.push_back(rand_vec());
    run_vectors("after_rst", 0, 0);

    for (int r = 0; r < 25; r++) begin
      vq = {};
      repeat ($urandom_range(8, 0)) vq.push_back(rand_vec());
      run_vectors($sformatf("rand%0d", r), 0, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
